// File: rtl/ysyx_22050710_ifu_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
// The fetch FSM state and the default boot address are kept here so the top and the bench agree on them.
package ysyx_22050710_ifu_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_IDLE = 2'd3
    } ifu_state_e;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22050710_sync_fifo.sv
// Single-clock circular FIFO with a synchronous flush and an occupancy count.
// A push while full or a pop while empty is ignored.
module ysyx_22050710_sync_fifo
    import ysyx_22050710_ifu_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & ~empty & ~flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22050710_ifu_pf.sv
// Prefetching IFU: keeps one SRAM read in flight, selects the 32-bit lane of each 64-bit beat,
// and buffers fetched instructions in a small queue toward decode. Redirects flush and retarget.
module ysyx_22050710_ifu_pf
    import ysyx_22050710_ifu_pkg::*;
#(
    parameter int              INST_WD      = 32,
    parameter int              PC_WD        = 64,
    parameter int              SRAM_ADDR_WD = 32,
    parameter int              SRAM_DATA_WD = 64,
    parameter int              FQ_DEPTH     = 4,
    parameter logic [PC_WD-1:0] RESET_PC    = DEFAULT_RESET_PC[PC_WD-1:0]
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_redirect_valid,
    input  logic [PC_WD-1:0]        i_redirect_pc,
    output logic                    o_inst_valid,
    output logic [INST_WD-1:0]      o_inst,
    output logic [PC_WD-1:0]        o_inst_pc,
    input  logic                    i_inst_ready,
    output logic                    o_inst_sram_req,
    output logic [SRAM_ADDR_WD-1:0] o_inst_sram_addr,
    input  logic                    i_inst_sram_addr_ok,
    input  logic                    i_inst_sram_data_ok,
    input  logic [SRAM_DATA_WD-1:0] i_inst_sram_rdata
);

    localparam int CNT_W  = $clog2(FQ_DEPTH) + 1;
    localparam int FIFO_W = PC_WD + INST_WD;

    ifu_state_e          state;
    ifu_state_e          state_next;
    logic [PC_WD-1:0]    fetch_pc;
    logic [INST_WD-1:0]  lane;
    logic                resp;
    logic                push;
    logic                pop;
    logic                credit;
    logic                empty;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic [FIFO_W-1:0]   head;

    // A response is data_ok while the request is outstanding; data_ok coinciding with addr_ok
    // in REQ is treated as the response to that same request.
    assign resp  = i_inst_sram_data_ok &
                   ((state == ST_WAIT) || ((state == ST_REQ) && i_inst_sram_addr_ok));
    assign push  = resp & ~i_redirect_valid;
    assign pop   = ~empty & i_inst_ready & ~i_redirect_valid;
    assign lane  = fetch_pc[2] ? i_inst_sram_rdata[2*INST_WD-1:INST_WD]
                               : i_inst_sram_rdata[INST_WD-1:0];

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign credit     = (count_next < CNT_W'(FQ_DEPTH));

    assign o_inst_sram_req  = (state == ST_REQ);
    assign o_inst_sram_addr = {fetch_pc[SRAM_ADDR_WD-1:3], 3'b000};
    assign o_inst_valid     = ~empty;
    assign {o_inst_pc, o_inst} = head;

    always_comb begin
        state_next = state;
        case (state)
            ST_REQ: begin
                if (i_inst_sram_addr_ok) begin
                    if (i_inst_sram_data_ok) begin
                        state_next = (i_redirect_valid || credit) ? ST_REQ : ST_IDLE;
                    end else begin
                        state_next = i_redirect_valid ? ST_DROP : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (i_inst_sram_data_ok) begin
                    state_next = (i_redirect_valid || credit) ? ST_REQ : ST_IDLE;
                end else if (i_redirect_valid) begin
                    state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                if (i_inst_sram_data_ok) begin
                    state_next = ST_REQ;
                end
            end
            ST_IDLE: begin
                if (i_redirect_valid || credit) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_REQ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_REQ;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_next;
            if (i_redirect_valid) begin
                fetch_pc <= i_redirect_pc;
            end else if (push) begin
                fetch_pc <= fetch_pc + PC_WD'(4);
            end
        end
    end

    ysyx_22050710_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (i_redirect_valid),
        .push      (push),
        .push_data ({fetch_pc, lane}),
        .pop       (pop),
        .pop_data  (head),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_ysyx_22050710_ifu_pf.sv
// Directed bench for the prefetching IFU: a latency-configurable SRAM responder plus a
// scoreboard of expected {pc, inst} entries checked at every decode handshake.
module tb_ysyx_22050710_ifu_pf;
    import ysyx_22050710_ifu_pkg::*;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_entry_t;

    logic        i_clk;
    logic        i_rst;
    logic        i_redirect_valid;
    logic [63:0] i_redirect_pc;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [63:0] o_inst_pc;
    logic        i_inst_ready;
    logic        o_inst_sram_req;
    logic [31:0] o_inst_sram_addr;
    logic        i_inst_sram_addr_ok;
    logic        i_inst_sram_data_ok;
    logic [63:0] i_inst_sram_rdata;

    logic        accept_en;
    int          resp_delay;
    logic        pend;
    int          lat_cnt;
    logic [31:0] paddr;

    exp_entry_t  exp_q[$];
    int          checks;
    int          errors;

    ysyx_22050710_ifu_pf dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_redirect_valid    (i_redirect_valid),
        .i_redirect_pc       (i_redirect_pc),
        .o_inst_valid        (o_inst_valid),
        .o_inst              (o_inst),
        .o_inst_pc           (o_inst_pc),
        .i_inst_ready        (i_inst_ready),
        .o_inst_sram_req     (o_inst_sram_req),
        .o_inst_sram_addr    (o_inst_sram_addr),
        .i_inst_sram_addr_ok (i_inst_sram_addr_ok),
        .i_inst_sram_data_ok (i_inst_sram_data_ok),
        .i_inst_sram_rdata   (i_inst_sram_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Instruction word stored at a given 32-bit word address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // SRAM responder: zero-latency accept, data_ok resp_delay cycles after the accept.
    assign i_inst_sram_addr_ok = o_inst_sram_req & accept_en;
    assign i_inst_sram_data_ok = pend && (lat_cnt == 0);
    assign i_inst_sram_rdata   = i_inst_sram_data_ok ? {inst_of(paddr + 32'd4), inst_of(paddr)}
                                                     : 64'hDEAD_BEEF_DEAD_BEEF;

    always @(posedge i_clk) begin
        if (i_rst) begin
            pend    <= 1'b0;
            lat_cnt <= 0;
            paddr   <= '0;
        end else begin
            if (i_inst_sram_data_ok) pend <= 1'b0;
            if (i_inst_sram_addr_ok) begin
                pend    <= 1'b1;
                lat_cnt <= resp_delay - 1;
                paddr   <= o_inst_sram_addr;
            end else if (pend && lat_cnt != 0) begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    task automatic check_output(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic expect_pc(input logic [63:0] pc);
        exp_entry_t e;
        e.pc   = pc;
        e.inst = inst_of(pc[31:0]);
        exp_q.push_back(e);
    endtask

    // One clock: score the handshake happening at the coming edge, then return just after it.
    task automatic step_cycle();
        exp_entry_t e;
        @(negedge i_clk);
        if (o_inst_valid && i_inst_ready && !i_redirect_valid && !i_rst) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_pop observed pc=%h expected no entry", o_inst_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("head_pc", 96'(o_inst_pc), 96'(e.pc));
                check_output("head_inst", 96'(o_inst), 96'(e.inst));
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step_cycle();
        check_output(tag, 96'(exp_q.size()), 96'd0);
    endtask

    task automatic do_reset();
        i_rst            = 1'b1;
        i_inst_ready     = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        accept_en        = 1'b1;
        resp_delay       = 1;
        exp_q.delete();
        step_cycle();
        step_cycle();
        check_output("rst_valid", 96'(o_inst_valid), 96'd0);
        i_rst = 1'b0;
        check_output("rst_req", 96'(o_inst_sram_req), 96'd1);
        check_output("rst_addr", 96'(o_inst_sram_addr), 96'h8000_0000);
    endtask

    task automatic apply_stimulus();
        // Reset, zero-latency SRAM, decode always ready.
        do_reset();
        for (int i = 0; i < 6; i++) expect_pc(64'h8000_0000 + 64'(4 * i));
        i_inst_ready = 1'b1;
        wait_drain("stream_drain", 100);
        i_inst_ready = 1'b0;

        // Backpressure fills the queue and parks the FSM.
        do_reset();
        for (int i = 0; i < 20; i++) step_cycle();
        check_output("bp_count", 96'(dut.u_fifo.count), 96'd4);
        check_output("bp_state", 96'(dut.state), 96'(ST_IDLE));
        check_output("bp_req", 96'(o_inst_sram_req), 96'd0);
        check_output("bp_head_pc", 96'(o_inst_pc), 96'h8000_0000);
        expect_pc(64'h8000_0000);
        i_inst_ready = 1'b1;
        step_cycle();
        i_inst_ready = 1'b0;
        check_output("bp_req_back", 96'(o_inst_sram_req), 96'd1);
        check_output("bp_addr_back", 96'(o_inst_sram_addr), 96'h8000_0010);
        check_output("bp_head_next", 96'(o_inst_pc), 96'h8000_0004);

        // Redirect while a request is outstanding; its late data must be dropped.
        do_reset();
        resp_delay = 3;
        step_cycle();
        check_output("wait_req_low", 96'(o_inst_sram_req), 96'd0);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 64'h8000_0100;
        step_cycle();
        i_redirect_valid = 1'b0;
        check_output("drop_valid", 96'(o_inst_valid), 96'd0);
        check_output("drop_req", 96'(o_inst_sram_req), 96'd0);
        for (int i = 0; i < 10 && !o_inst_sram_req; i++) step_cycle();
        check_output("redir_req", 96'(o_inst_sram_req), 96'd1);
        check_output("redir_addr", 96'(o_inst_sram_addr), 96'h8000_0100);
        expect_pc(64'h8000_0100);
        expect_pc(64'h8000_0104);
        i_inst_ready = 1'b1;
        wait_drain("redir_drain", 60);
        i_inst_ready = 1'b0;

        // Redirect while the request is stalled by the SRAM.
        do_reset();
        accept_en = 1'b0;
        step_cycle();
        step_cycle();
        check_output("stall_addr", 96'(o_inst_sram_addr), 96'h8000_0000);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 64'h8000_0200;
        step_cycle();
        i_redirect_valid = 1'b0;
        check_output("stall_redir_addr", 96'(o_inst_sram_addr), 96'h8000_0200);
        check_output("stall_redir_req", 96'(o_inst_sram_req), 96'd1);
        check_output("stall_valid", 96'(o_inst_valid), 96'd0);
        for (int i = 0; i < 3; i++) step_cycle();
        accept_en = 1'b1;
        expect_pc(64'h8000_0200);
        expect_pc(64'h8000_0204);
        i_inst_ready = 1'b1;
        wait_drain("stall_drain", 60);
        i_inst_ready = 1'b0;

        // Redirect coinciding with data_ok when the queue is one short of full.
        do_reset();
        for (int i = 0; i < 40 && !(dut.u_fifo.count == 3 && i_inst_sram_data_ok); i++) step_cycle();
        check_output("fm1_setup", 96'(dut.u_fifo.count == 3 && i_inst_sram_data_ok), 96'd1);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 64'h8000_0300;
        step_cycle();
        i_redirect_valid = 1'b0;
        check_output("fm1_valid", 96'(o_inst_valid), 96'd0);
        check_output("fm1_count", 96'(dut.u_fifo.count), 96'd0);
        check_output("fm1_state", 96'(dut.state), 96'(ST_REQ));
        check_output("fm1_addr", 96'(o_inst_sram_addr), 96'h8000_0300);
        expect_pc(64'h8000_0300);
        i_inst_ready = 1'b1;
        wait_drain("fm1_drain", 40);
        i_inst_ready = 1'b0;

        // Fetch PC wraps from the top of the address space to zero.
        do_reset();
        accept_en        = 1'b0;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step_cycle();
        i_redirect_valid = 1'b0;
        accept_en        = 1'b1;
        check_output("wrap_addr_top", 96'(o_inst_sram_addr), 96'hFFFF_FFF8);
        for (int i = 0; i < 20 && !o_inst_valid; i++) step_cycle();
        check_output("wrap_fetch_pc", 96'(dut.fetch_pc), 96'd0);
        check_output("wrap_addr_zero", 96'(o_inst_sram_addr), 96'd0);
        expect_pc(64'hFFFF_FFFF_FFFF_FFFC);
        expect_pc(64'h0);
        i_inst_ready = 1'b1;
        wait_drain("wrap_drain", 40);
        i_inst_ready = 1'b0;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        i_rst            = 1'b1;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_inst_ready     = 1'b0;
        accept_en        = 1'b1;
        resp_delay       = 1;
        $display("[TB] starting ysyx_22050710_ifu_pf bench");
        apply_stimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
